// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types used by the MEM stage: funct3 encodings,
// write-back select, the EX/MEM and MEM/WB register layouts and the
// data-memory handshake state enum.
package rv32i_types;

  // Load funct3 encodings.
  localparam logic [2:0] load_f3_lb  = 3'b000;
  localparam logic [2:0] load_f3_lh  = 3'b001;
  localparam logic [2:0] load_f3_lw  = 3'b010;
  localparam logic [2:0] load_f3_lbu = 3'b100;
  localparam logic [2:0] load_f3_lhu = 3'b101;

  // Store funct3 encodings.
  localparam logic [2:0] store_f3_sb = 3'b000;
  localparam logic [2:0] store_f3_sh = 3'b001;
  localparam logic [2:0] store_f3_sw = 3'b010;

  // Which value the write-back stage commits to the register file.
  typedef enum logic [1:0] {
    wb_sel_alu  = 2'b00,
    wb_sel_cmp  = 2'b01,
    wb_sel_lui  = 2'b10,
    wb_sel_load = 2'b11
  } wb_sel_t;

  typedef struct packed {
    logic    regf_we;
    wb_sel_t wb_sel;
  } wb_ctrl_t;

  typedef struct packed {
    logic [2:0] funct3;
  } mem_ctrl_t;

  // Data-memory handshake states of the MEM stage.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mem_state_t;

  typedef struct packed {
    logic        valid_s;
    mem_ctrl_t   mem_ctrl;
    logic [31:0] dmem_addr_s;
    logic [3:0]  dmem_rmask_s;
    logic [3:0]  dmem_wmask_s;
    logic [31:0] dmem_wdata_s;
    logic [31:0] mem_addr_s;
    logic [31:0] alu_out_s;
    logic [31:0] u_imm_s;
    logic        br_en_s;
    wb_ctrl_t    wb_ctrl;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] pc_s;
    logic [63:0] order_s;
    logic [31:0] inst_s;
  } ex_mem_stage_reg_t;

  typedef struct packed {
    logic        valid_s;
    mem_ctrl_t   mem_ctrl;
    wb_ctrl_t    wb_ctrl;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] pc_s;
    logic [63:0] order_s;
    logic [31:0] inst_s;
    logic [31:0] alu_out_s;
    logic [31:0] u_imm_s;
    logic        br_en_s;
    logic [31:0] load_data_s;
    logic [31:0] mem_addr_s;
    logic [31:0] dmem_addr_s;
    logic [3:0]  dmem_rmask_s;
    logic [3:0]  dmem_wmask_s;
    logic [31:0] dmem_wdata_s;
    logic [31:0] dmem_rdata_s;
  } mem_wb_stage_reg_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load formatter: picks the addressed byte/halfword out of
// the raw memory word and sign- or zero-extends it according to funct3.
module load_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane selection: byte by the low two address bits, halfword by bit 1.
  always_comb begin
    byte_v = rdata[7:0];
    case (addr)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension by load type; lw and any unknown encoding pass the word through.
  always_comb begin
    result = rdata;
    case (funct3)
      load_f3_lb:  result = {{24{byte_v[7]}}, byte_v};
      load_f3_lbu: result = {24'd0, byte_v};
      load_f3_lh:  result = {{16{half_v[15]}}, half_v};
      load_f3_lhu: result = {16'd0, half_v};
      default:     result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory request per load/store, holds
// the pipeline until the response, buffers a response that arrives while the
// rest of the pipeline is stalled, formats load data and registers MEM/WB.
module mem_stage
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              move,
  input  ex_mem_stage_reg_t ex_mem_reg,
  output logic [31:0]       dmem_addr,
  output logic [3:0]        dmem_rmask,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output logic              dmem_stall,
  output logic [31:0]       forward_mem_v,
  output mem_wb_stage_reg_t mem_wb_reg
);

  mem_state_t  state;
  mem_state_t  next_state;
  logic [31:0] hold_q;
  logic        capture;
  logic        mem_op;
  logic [31:0] raw_rdata;
  logic [31:0] load_data;

  assign mem_op = ex_mem_reg.valid_s &
                  (|(ex_mem_reg.dmem_rmask_s | ex_mem_reg.dmem_wmask_s));

  // State register; reset drops any in-flight access back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and memory request/stall outputs. The request is visible for
  // the single IDLE cycle only, so memory never sees a repeated request.
  // Responses outside BUSY fall through untouched.
  always_comb begin
    next_state = state;
    dmem_addr  = 32'd0;
    dmem_rmask = 4'd0;
    dmem_wmask = 4'd0;
    dmem_wdata = 32'd0;
    dmem_stall = 1'b0;
    capture    = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            dmem_addr  = ex_mem_reg.dmem_addr_s;
            dmem_rmask = ex_mem_reg.dmem_rmask_s;
            dmem_wmask = ex_mem_reg.dmem_wmask_s;
            dmem_wdata = ex_mem_reg.dmem_wdata_s;
            dmem_stall = 1'b1;
            next_state = BUSY;
          end
        end
        BUSY: begin
          dmem_stall = ~dmem_resp;
          if (dmem_resp) begin
            if (move) begin
              next_state = IDLE;
            end else begin
              capture    = 1'b1;
              next_state = DONE;
            end
          end
        end
        DONE: begin
          if (move) begin
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Hold register keeps a response that arrived while the pipeline was frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= 32'd0;
    end else if (capture) begin
      hold_q <= dmem_rdata;
    end
  end

  // Raw word for formatting: buffered copy in DONE, live bus otherwise.
  always_comb begin
    raw_rdata = (state == DONE) ? hold_q : dmem_rdata;
  end

  load_align u_load_align (
    .funct3 (ex_mem_reg.mem_ctrl.funct3),
    .addr   (ex_mem_reg.mem_addr_s[1:0]),
    .rdata  (raw_rdata),
    .result (load_data)
  );

  // Forwarding value for EX: whatever this instruction will write that is
  // already known here. Load data is deliberately excluded.
  always_comb begin
    forward_mem_v = ex_mem_reg.alu_out_s;
    case (ex_mem_reg.wb_ctrl.wb_sel)
      wb_sel_lui: forward_mem_v = ex_mem_reg.u_imm_s;
      wb_sel_cmp: forward_mem_v = {31'd0, ex_mem_reg.br_en_s};
      default:    forward_mem_v = ex_mem_reg.alu_out_s;
    endcase
  end

  // MEM/WB register: valid bubbles whenever the pipeline does not advance,
  // payload only loads on advance so it holds steady during stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wb_reg <= '0;
    end else begin
      mem_wb_reg.valid_s <= move & ex_mem_reg.valid_s;
      if (move) begin
        mem_wb_reg.mem_ctrl     <= ex_mem_reg.mem_ctrl;
        mem_wb_reg.wb_ctrl      <= ex_mem_reg.wb_ctrl;
        mem_wb_reg.rd_s         <= ex_mem_reg.rd_s;
        mem_wb_reg.rs1_s        <= ex_mem_reg.rs1_s;
        mem_wb_reg.rs2_s        <= ex_mem_reg.rs2_s;
        mem_wb_reg.pc_s         <= ex_mem_reg.pc_s;
        mem_wb_reg.order_s      <= ex_mem_reg.order_s;
        mem_wb_reg.inst_s       <= ex_mem_reg.inst_s;
        mem_wb_reg.alu_out_s    <= ex_mem_reg.alu_out_s;
        mem_wb_reg.u_imm_s      <= ex_mem_reg.u_imm_s;
        mem_wb_reg.br_en_s      <= ex_mem_reg.br_en_s;
        mem_wb_reg.load_data_s  <= load_data;
        mem_wb_reg.mem_addr_s   <= ex_mem_reg.mem_addr_s;
        mem_wb_reg.dmem_addr_s  <= ex_mem_reg.dmem_addr_s;
        mem_wb_reg.dmem_rmask_s <= ex_mem_reg.dmem_rmask_s;
        mem_wb_reg.dmem_wmask_s <= ex_mem_reg.dmem_wmask_s;
        mem_wb_reg.dmem_wdata_s <= ex_mem_reg.dmem_wdata_s;
        mem_wb_reg.dmem_rdata_s <= raw_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by randomized
// loads/stores/ALU ops with random memory latency and extra stall cycles.
module tb_mem_stage;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              move = 1'b0;
  ex_mem_stage_reg_t ex_mem_reg;
  logic [31:0]       dmem_addr;
  logic [3:0]        dmem_rmask;
  logic [3:0]        dmem_wmask;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_resp;
  logic              dmem_stall;
  logic [31:0]       forward_mem_v;
  mem_wb_stage_reg_t mem_wb_reg;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .move          (move),
    .ex_mem_reg    (ex_mem_reg),
    .dmem_addr     (dmem_addr),
    .dmem_rmask    (dmem_rmask),
    .dmem_wmask    (dmem_wmask),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_resp     (dmem_resp),
    .dmem_stall    (dmem_stall),
    .forward_mem_v (forward_mem_v),
    .mem_wb_reg    (mem_wb_reg)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference load result from the ISA rules using shifts and arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] v;
    logic [1:0]  lo;
    lo = addr[1:0];
    v  = rdata;
    if (f3 == load_f3_lb || f3 == load_f3_lbu) begin
      v = (rdata >> (8 * lo)) & 32'h0000_00FF;
      if (f3 == load_f3_lb && v >= 32'd128) v = v - 32'd256;
    end else if (f3 == load_f3_lh || f3 == load_f3_lhu) begin
      v = (rdata >> (16 * lo[1])) & 32'h0000_FFFF;
      if (f3 == load_f3_lh && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  // Reference forwarding value: the known non-load write-back result.
  function automatic logic [31:0] ref_forward(input ex_mem_stage_reg_t r);
    if (r.wb_ctrl.wb_sel == wb_sel_lui) return r.u_imm_s;
    if (r.wb_ctrl.wb_sel == wb_sel_cmp) return r.br_en_s ? 32'd1 : 32'd0;
    return r.alu_out_s;
  endfunction

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // One instruction through the stage.
  // kind: 0 = ALU random wb select, 1 = load, 2 = store, 3 = plain ALU.
  // data: alu_out for ALU, returned rdata for loads, wdata for stores.
  // lat: BUSY cycles before the response; hold: move=0 cycles from the
  // response cycle onward (0 means the pipeline advances on the response).
  task automatic applyStimulus(input int kind, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data,
                               input int lat, input int hold);
    ex_mem_stage_reg_t t;
    logic [3:0]  m;
    logic [31:0] rdata_used;
    t = '0;
    t.valid_s         = 1'b1;
    t.mem_ctrl.funct3 = f3;
    t.mem_addr_s      = addr;
    t.dmem_addr_s     = addr & 32'hFFFF_FFFC;
    t.alu_out_s       = $urandom;
    t.u_imm_s         = $urandom & 32'hFFFF_F000;
    t.br_en_s         = 1'($urandom_range(0, 1));
    t.rd_s            = 5'($urandom_range(1, 31));
    t.rs1_s           = 5'($urandom_range(0, 31));
    t.rs2_s           = 5'($urandom_range(0, 31));
    t.pc_s            = $urandom & 32'hFFFF_FFFC;
    t.order_s         = {32'd0, $urandom};
    t.inst_s          = $urandom;
    t.dmem_wdata_s    = $urandom;
    m = 4'b1111;
    if (f3[1:0] == 2'b01) m = 4'b0011 << {addr[1], 1'b0};
    if (f3[1:0] == 2'b00) m = 4'b0001 << addr[1:0];
    if (kind == 1) begin
      t.dmem_rmask_s   = m;
      t.wb_ctrl        = '{regf_we: 1'b1, wb_sel: wb_sel_load};
    end else if (kind == 2) begin
      t.dmem_wmask_s   = m;
      t.dmem_wdata_s   = data;
      t.wb_ctrl        = '{regf_we: 1'b0, wb_sel: wb_sel_alu};
    end else begin
      t.dmem_addr_s    = 32'd0;
      t.alu_out_s      = data;
      t.wb_ctrl.regf_we = 1'b1;
      t.wb_ctrl.wb_sel = (kind == 3) ? wb_sel_alu
                                     : wb_sel_t'(2'($urandom_range(0, 2)));
    end
    ex_mem_reg = t;
    dmem_resp  = 1'b0;
    dmem_rdata = $urandom;
    rdata_used = data;

    if (kind == 0 || kind == 3) begin
      move = 1'b1;
      #2;
      checkOutput("alu_stall", 32'(dmem_stall), 32'd0);
      checkOutput("alu_masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
      checkOutput("alu_fwd", forward_mem_v, ref_forward(t));
      next_edge();
    end else begin
      move = 1'b0;
      #2;
      checkOutput("req_addr", dmem_addr, t.dmem_addr_s);
      checkOutput("req_rmask", 32'(dmem_rmask), 32'(t.dmem_rmask_s));
      checkOutput("req_wmask", 32'(dmem_wmask), 32'(t.dmem_wmask_s));
      checkOutput("req_wdata", dmem_wdata, t.dmem_wdata_s);
      checkOutput("req_stall", 32'(dmem_stall), 32'd1);
      checkOutput("mem_fwd", forward_mem_v, ref_forward(t));
      next_edge();
      checkOutput("req_nocommit", 32'(mem_wb_reg.valid_s), 32'd0);
      for (int i = 0; i < lat; i++) begin
        dmem_rdata = $urandom;
        #2;
        checkOutput("busy_stall", 32'(dmem_stall), 32'd1);
        checkOutput("busy_masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
        next_edge();
        checkOutput("busy_nocommit", 32'(mem_wb_reg.valid_s), 32'd0);
      end
      if (kind == 2) rdata_used = $urandom;
      dmem_resp  = 1'b1;
      dmem_rdata = rdata_used;
      move       = (hold == 0);
      #2;
      checkOutput("resp_stall", 32'(dmem_stall), 32'd0);
      checkOutput("resp_masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
      next_edge();
      dmem_resp  = 1'b0;
      dmem_rdata = $urandom;
      if (hold > 0) begin
        checkOutput("hold_nocommit", 32'(mem_wb_reg.valid_s), 32'd0);
        for (int i = 1; i < hold; i++) begin
          move       = 1'b0;
          dmem_resp  = 1'($urandom_range(0, 1));
          dmem_rdata = $urandom;
          #2;
          checkOutput("done_stall", 32'(dmem_stall), 32'd0);
          checkOutput("done_masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
          next_edge();
          checkOutput("done_nocommit", 32'(mem_wb_reg.valid_s), 32'd0);
        end
        move       = 1'b1;
        dmem_resp  = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        #2;
        checkOutput("done_stall", 32'(dmem_stall), 32'd0);
        next_edge();
        dmem_resp  = 1'b0;
      end
    end

    checkOutput("wb_valid", 32'(mem_wb_reg.valid_s), 32'd1);
    checkOutput("wb_pc", mem_wb_reg.pc_s, t.pc_s);
    checkOutput("wb_rd", 32'(mem_wb_reg.rd_s), 32'(t.rd_s));
    checkOutput("wb_alu", mem_wb_reg.alu_out_s, t.alu_out_s);
    if (kind == 1) begin
      checkOutput("wb_load", mem_wb_reg.load_data_s, ref_load(f3, addr, rdata_used));
      checkOutput("wb_rdata", mem_wb_reg.dmem_rdata_s, rdata_used);
      checkOutput("wb_daddr", mem_wb_reg.dmem_addr_s, t.dmem_addr_s);
      checkOutput("wb_rmask", 32'(mem_wb_reg.dmem_rmask_s), 32'(t.dmem_rmask_s));
    end
    if (kind == 2) begin
      checkOutput("wb_wmask", 32'(mem_wb_reg.dmem_wmask_s), 32'(t.dmem_wmask_s));
      checkOutput("wb_wdata", mem_wb_reg.dmem_wdata_s, t.dmem_wdata_s);
    end
  endtask

  logic [2:0] load_f3s [5];
  logic [2:0] store_f3s [3];

  initial begin
    load_f3s  = '{load_f3_lb, load_f3_lh, load_f3_lw, load_f3_lbu, load_f3_lhu};
    store_f3s = '{store_f3_sb, store_f3_sh, store_f3_sw};
    ex_mem_reg = '0;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'd0;
    move       = 1'b0;
    rst        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(mem_wb_reg.valid_s), 32'd0);
    checkOutput("rst_pc", mem_wb_reg.pc_s, 32'd0);
    checkOutput("rst_stall", 32'(dmem_stall), 32'd0);
    rst = 1'b1;
    #2;

    $display("[TB] directed scenarios");
    applyStimulus(1, load_f3_lw,  32'h100, 32'hDEAD_BEEF, 2, 0);
    applyStimulus(1, load_f3_lb,  32'h103, 32'h8011_2233, 1, 0);
    applyStimulus(1, load_f3_lbu, 32'h103, 32'h8011_2233, 0, 0);
    applyStimulus(1, load_f3_lh,  32'h102, 32'h8011_2233, 1, 0);
    applyStimulus(2, store_f3_sw, 32'h200, 32'h1234_5678, 1, 0);
    applyStimulus(1, load_f3_lw,  32'h300, 32'hA5A5_A5A5, 1, 3);
    applyStimulus(3, 3'd0,        32'h0,   32'h0000_0042, 0, 0);

    $display("[TB] reset during BUSY");
    ex_mem_reg = '0;
    ex_mem_reg.valid_s      = 1'b1;
    ex_mem_reg.dmem_rmask_s = 4'b1111;
    ex_mem_reg.dmem_addr_s  = 32'h400;
    ex_mem_reg.mem_addr_s   = 32'h400;
    ex_mem_reg.mem_ctrl.funct3 = load_f3_lw;
    move = 1'b0;
    #2;
    checkOutput("rb_req_stall", 32'(dmem_stall), 32'd1);
    next_edge();
    #2;
    checkOutput("rb_busy_stall", 32'(dmem_stall), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("rb_rst_stall", 32'(dmem_stall), 32'd0);
    checkOutput("rb_rst_masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
    checkOutput("rb_rst_valid", 32'(mem_wb_reg.valid_s), 32'd0);
    next_edge();
    ex_mem_reg.valid_s = 1'b0;
    rst = 1'b1;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    #2;
    checkOutput("rb_stray_stall", 32'(dmem_stall), 32'd0);
    next_edge();
    dmem_resp = 1'b0;
    move = 1'b1;
    #2;
    checkOutput("rb_idle_stall", 32'(dmem_stall), 32'd0);
    checkOutput("rb_nocommit", 32'(mem_wb_reg.valid_s), 32'd0);
    next_edge();
    checkOutput("rb_bubble", 32'(mem_wb_reg.valid_s), 32'd0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 120; n++) begin
      int kind;
      logic [2:0] f3;
      kind = $urandom_range(0, 2);
      f3 = (kind == 1) ? load_f3s[$urandom_range(0, 4)]
                       : store_f3s[$urandom_range(0, 2)];
      applyStimulus(kind, f3, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
